// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding command sequencer for the dual-read,
// single-write data memory. Paired reads and single writes arrive on a
// valid/ready command port; results leave on a valid/ready response port.
module mem_access_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data_a,
  output logic [DATA_W-1:0] rsp_data_b,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addrA,
  output logic [ADDR_W-1:0] mem_addrB,
  output logic [ADDR_W-1:0] mem_addrWR,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_memread,
  output logic              mem_memwrite,
  input  logic [DATA_W-1:0] mem_read_dataA,
  input  logic [DATA_W-1:0] mem_read_dataB,
  output logic [CNT_W-1:0]  txn_count,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPT,
    WR_ISSUE,
    RESP
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   addr_a_bad;
  logic   addr_b_bad;
  logic   cmd_bad;
  logic   rsp_fire;

  assign cmd_ready  = (state == IDLE);
  assign accept     = cmd_valid && cmd_ready;
  // Full-width compare: any upper bit set is out of range, never wrapped.
  assign addr_a_bad = (cmd_addr_a >= DEPTH_A);
  assign addr_b_bad = !cmd_write && (cmd_addr_b >= DEPTH_A);
  assign cmd_bad    = addr_a_bad || addr_b_bad;
  assign rsp_fire   = rsp_valid && rsp_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_bad)        state_nxt = RESP;
          else if (cmd_write) state_nxt = WR_ISSUE;
          else                state_nxt = RD_ISSUE;
        end
      end
      RD_ISSUE: state_nxt = RD_CAPT;
      RD_CAPT:  state_nxt = RESP;
      WR_ISSUE: state_nxt = RESP;
      RESP:     if (rsp_fire) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Registered memory strobes, bus lines, response fields and counters.
  // Strobes and rsp_valid are registered copies of the next-state decode so
  // they line up exactly with RD_ISSUE / WR_ISSUE / RESP and clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_addrA      <= '0;
      mem_addrB      <= '0;
      mem_addrWR     <= '0;
      mem_write_data <= '0;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_data_a     <= '0;
      rsp_data_b     <= '0;
      txn_count      <= '0;
      err_count      <= '0;
    end else begin
      mem_memread  <= (state_nxt == RD_ISSUE);
      mem_memwrite <= (state_nxt == WR_ISSUE);
      rsp_valid    <= (state_nxt == RESP);
      if (accept) begin
        rsp_err    <= cmd_bad;
        rsp_data_a <= '0;
        rsp_data_b <= '0;
        // Buses only move for commands that will actually reach the memory.
        if (!cmd_bad && !cmd_write) begin
          mem_addrA <= cmd_addr_a;
          mem_addrB <= cmd_addr_b;
        end
        if (!cmd_bad && cmd_write) begin
          mem_addrWR     <= cmd_addr_a;
          mem_write_data <= cmd_wdata;
        end
      end
      if (state == RD_CAPT) begin
        rsp_data_a <= mem_read_dataA;
        rsp_data_b <= mem_read_dataB;
      end
      if (rsp_fire) begin
        txn_count <= txn_count + CNT_W'(1);
        if (rsp_err) err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator/sequencer for the dual-read, single-write data memory (MemoriaDeco).
- Accepts one command at a time on a valid/ready command port: either a paired read (A, B) or a single write.
- Drives the memory's address, data, memread and memwrite lines, and honours the memory's timing: read sampled at posedge, write committed at negedge.
- Returns the result on a valid/ready response port with backpressure; sits between the datapath/control unit and the memory.

Parameters:
- DATA_W, 32, memory word width.
- ADDR_W, 32, address bus width.
- DEPTH, 32, number of implemented memory words; addresses >= DEPTH are out of range.
- CNT_W, 16, width of the transaction and error counters.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous reset, active low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_write  input  1  1 = write, 0 = paired read.
- cmd_addr_a  input  ADDR_W  read address A, or write address.
- cmd_addr_b  input  ADDR_W  read address B; ignored on writes.
- cmd_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_data_a  output  DATA_W  read data A; 0 on writes and errors.
- rsp_data_b  output  DATA_W  read data B; 0 on writes and errors.
- rsp_err  output  1  command rejected, address out of range.
- mem_addrA  output  ADDR_W  to memory addrA.
- mem_addrB  output  ADDR_W  to memory addrB.
- mem_addrWR  output  ADDR_W  to memory addrWR.
- mem_write_data  output  DATA_W  to memory write_data.
- mem_memread  output  1  to memory memread.
- mem_memwrite  output  1  to memory memwrite.
- mem_read_dataA  input  DATA_W  from memory read_dataA.
- mem_read_dataB  input  DATA_W  from memory read_dataB.
- txn_count  output  CNT_W  completed responses, including errors.
- err_count  output  CNT_W  error responses.

Behaviour:

Reset (rst_n low, asynchronous):
- State = IDLE.
- All registered outputs = 0: mem_* outputs, rsp_*, both counters.
- cmd_ready = 1 as soon as reset releases.

State machine:
- cmd_ready = (state == IDLE), decoded combinationally from the state register.
- Command accepted on the posedge where cmd_valid && cmd_ready; the command fields are latched on that edge.

State transitions:
- IDLE -> RD_ISSUE: accepted read, both addresses < DEPTH.
- IDLE -> WR_ISSUE: accepted write, address < DEPTH.
- IDLE -> RESP: any out-of-range address (A, or B on a read). rsp_err = 1, rsp_data = 0, no memread/memwrite pulse.
- RD_ISSUE (1 cycle): mem_addrA/B = latched addresses, mem_memread = 1. Memory samples at the closing posedge. -> RD_CAPT.
- RD_CAPT (1 cycle): mem_memread = 0. At the closing posedge, rsp_data_a/b <= mem_read_dataA/B. -> RESP.
- WR_ISSUE (1 cycle): mem_addrWR and mem_write_data driven, mem_memwrite = 1. Memory commits at the mid-cycle negedge. -> RESP, with rsp_err = 0 and rsp_data = 0.
- RESP: rsp_valid = 1. Response fields are held stable until rsp_ready. On the posedge with rsp_valid && rsp_ready: txn_count += 1, err_count += rsp_err, -> IDLE, and rsp_valid deasserts on that edge.

Latency, accept edge N:
- Read: rsp_valid high from edge N+3.
- Write: rsp_valid high from edge N+2.
- Error: rsp_valid high from edge N+1.
- Minimum turnaround, with rsp_ready held 1: read 4 cycles, write 3, error 2.

Interface rules:
- mem_memread and mem_memwrite are never both 1, and each is high for exactly one cycle per command.
- mem_addr* and mem_write_data hold their last values outside the issue states. No bus toggling when idle.
- Read-after-write: a read accepted after a write's response completes always returns the new data, since the write commits at least 1.5 cycles before the read sample.
- Same-address pair read (A == B): both responses carry identical data.
- Address compare is on the full ADDR_W bits, so upper bits set means out of range. No wrap-around.
- Counters wrap modulo 2^CNT_W and do not saturate.
- cmd_valid while busy: ignored; the upstream must hold the command.
- rsp_ready high with no rsp_valid: no effect.

Reset mid-operation:
- Memread/memwrite drop immediately.
- A write reset before its negedge is not committed.
- Any pending response is discarded, and the counters clear.

Test Plan:
1. Reset, then write addr 5 data 0xDEADBEEF with rsp_ready = 1 -> mem_memwrite high exactly one cycle with addrWR = 5; rsp_valid at N+2, err = 0; txn_count = 1.
2. Read A = 5, B = 7 after scenario 1 (memory initialised to MEMO[i] = i) -> memread one cycle; rsp at N+3 with data_a = 0xDEADBEEF, data_b = 7.
3. Read A = 3, B = 40 -> no memread pulse; rsp_valid at N+1, rsp_err = 1, data 0; err_count = 1.
4. Read A = B = 12 with rsp_ready held 0 for 5 cycles -> rsp_valid and data_a = data_b = 12 stay stable; cmd_ready = 0 throughout; one transaction counted after release.
5. Back-to-back write 9 = 0x55 then read 9,9 with cmd_valid held high -> read returns 0x55; cmd_ready low during all issue/resp states.
6. Assert rst_n low during WR_ISSUE, before the negedge -> memwrite drops immediately; later read of that address returns the old value; counters = 0, cmd_ready = 1 after release.
